// File: rtl/sntrup_pkg.sv
// Shared constants, ternary codes and encoder state type for the small-polynomial encoder.
package sntrup_pkg;

   localparam int P      = 757;
   localparam int W      = 286;
   localparam int NBYTES = (P + 3) / 4;

   // Wide enough to hold a coefficient index or weight count up to P
   localparam int KW = 10;

   localparam logic [1:0] TERN_NEG  = 2'd0;
   localparam logic [1:0] TERN_ZERO = 2'd1;
   localparam logic [1:0] TERN_POS  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EMIT,
      ST_FIN
   } enc_state_e;

endpackage

// File: rtl/small_tern_map.sv
// Maps one DW-bit two's-complement coefficient to its 2-bit ternary code, flagging
// anything outside {-1,0,1} (those map to the zero code).
module small_tern_map
   import sntrup_pkg::*;
#(
   parameter int DW = 13
) (
   input  logic [DW-1:0] coef_i,
   output logic [1:0]    code_o,
   output logic          err_o
);

   always_comb begin
      code_o = TERN_ZERO;
      err_o  = 1'b0;
      if (coef_i == DW'(1)) begin
         code_o = TERN_POS;
      end else if (coef_i == '0) begin
         code_o = TERN_ZERO;
      end else if (coef_i == '1) begin
         code_o = TERN_NEG;
      end else begin
         err_o = 1'b1;
      end
   end

endmodule

// File: rtl/small_encode.sv
// Reads P ternary coefficients back from memory and packs four per byte onto a
// valid/ready stream. Optional weight check enabled by SMALL_ENCODE_WEIGHT_CHECK_EN.
module small_encode
   import sntrup_pkg::*;
#(
   parameter int AW = 11,
   parameter int DW = 13,
   parameter logic [AW-1:0] BASE_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] mem_address_o,
   input  logic [DW-1:0] mem_output,
   output logic [7:0]    out_byte,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic          busy,
   output logic          done,
   output logic          coef_err,
   output logic          weight_ok
);

   enc_state_e    state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [2:0]    j_q, j_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    slots_q, slots_d;
   logic          coefErr_q, coefErr_d;

   logic [KW-1:0] remaining;
   logic [2:0]    groupN;
   logic          lastGroup;
   logic          capture;
   logic [2:0]    jMinus1;
   logic [1:0]    mapCode;
   logic          mapErr;

   small_tern_map #(.DW(DW)) u_map (
      .coef_i (mem_output),
      .code_o (mapCode),
      .err_o  (mapErr)
   );

   // Group size is min(4, P-k); read data for slot j arrives while j_q == j+1
   assign remaining = KW'(P) - k_q;
   assign groupN    = (remaining >= KW'(4)) ? 3'd4 : remaining[2:0];
   assign lastGroup = (remaining <= KW'(4));
   assign capture   = (state_q == ST_FETCH) && (j_q != 3'd0);
   assign jMinus1   = j_q - 3'd1;

   // Next-state and stream handshake; addresses are registered so they hold outside FETCH
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      j_d       = j_q;
      addr_d    = addr_q;
      slots_d   = slots_q;
      coefErr_d = coefErr_q;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      busy      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_FETCH;
               k_d       = '0;
               j_d       = 3'd0;
               addr_d    = BASE_ADDR;
               slots_d   = '0;
               coefErr_d = 1'b0;
            end
         end
         ST_FETCH: begin
            busy = 1'b1;
            if (capture) begin
               slots_d[{jMinus1[1:0], 1'b0} +: 2] = mapCode;
               if (mapErr) begin
                  coefErr_d = 1'b1;
               end
            end
            if (j_q == groupN) begin
               state_d = ST_EMIT;
            end else begin
               j_d = j_q + 3'd1;
               if ((j_q + 3'd1) < groupN) begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end
         ST_EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = lastGroup;
            if (out_ready) begin
               k_d = k_q + KW'(groupN);
               if (lastGroup) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_FETCH;
                  j_d     = 3'd0;
                  slots_d = '0;
                  addr_d  = BASE_ADDR + AW'(k_q + KW'(groupN));
               end
            end
         end
         ST_FIN: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         k_q       <= '0;
         j_q       <= '0;
         addr_q    <= '0;
         slots_q   <= '0;
         coefErr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         j_q       <= j_d;
         addr_q    <= addr_d;
         slots_q   <= slots_d;
         coefErr_q <= coefErr_d;
      end
   end

   assign mem_address_o = addr_q;
   assign out_byte      = slots_q;
   assign coef_err      = coefErr_q;

`ifdef SMALL_ENCODE_WEIGHT_CHECK_EN
   logic [KW-1:0] weightCnt_q, weightCnt_d;
   logic          weightOk_q, weightOk_d;
   logic          xferLast;

   assign xferLast = (state_q == ST_EMIT) && out_ready && lastGroup;

   // The count is complete once the last group is captured, so it is judged on the final transfer
   always_comb begin
      weightCnt_d = weightCnt_q;
      weightOk_d  = weightOk_q;
      if ((state_q == ST_IDLE) && start) begin
         weightCnt_d = '0;
      end else if (capture && !mapErr && (mapCode != TERN_ZERO)) begin
         weightCnt_d = weightCnt_q + 1'b1;
      end
      if (xferLast) begin
         weightOk_d = (weightCnt_q == KW'(W));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weightCnt_q <= '0;
         weightOk_q  <= 1'b1;
      end else begin
         weightCnt_q <= weightCnt_d;
         weightOk_q  <= weightOk_d;
      end
   end

   assign weight_ok = weightOk_q;
`else
   assign weight_ok = 1'b1;
`endif

endmodule

// File: tb/tb_small_encode.sv
// Directed bench for small_encode: packing patterns, back-pressure, range errors,
// weight result (both SMALL_ENCODE_WEIGHT_CHECK_EN builds) and mid-stream reset.
module tb_small_encode;

   localparam int NB   = 190;
   localparam int NCOF = 757;

   logic        clk;
   logic        rst;
   logic        start;
   logic [10:0] mem_address_o;
   logic [12:0] mem_output;
   logic [7:0]  out_byte;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        coef_err;
   logic        weight_ok;

   logic [12:0] mem [0:2047];

   int errors = 0;
   int checks = 0;

   logic [7:0] got [0:255];
   logic       gotLast [0:255];
   logic       errAt [0:255];
   int         nGot;
   bit         gotDone;
   int         doneCycle;
   int         doneGap;
   int         firstValid;
   logic       doneErr;
   logic       doneWok;

   small_encode dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .mem_address_o (mem_address_o),
      .mem_output    (mem_output),
      .out_byte      (out_byte),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done),
      .coef_err      (coef_err),
      .weight_ok     (weight_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memory: data appears the cycle after the address
   always @(posedge clk) mem_output <= mem[mem_address_o];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [1:0] ternCode(input logic [12:0] v);
      if (v == 13'h0001) return 2'd2;
      if (v == 13'h0000) return 2'd1;
      if (v == 13'h1FFF) return 2'd0;
      return 2'd1;
   endfunction

   function automatic logic [7:0] modelByte(input int b);
      logic [7:0] r;
      r = 8'h00;
      for (int j = 0; j < 4; j++) begin
         if (4 * b + j < NCOF) r[2*j +: 2] = ternCode(mem[4*b+j]);
      end
      return r;
   endfunction

   // Runs one encode; readyMode 0 = always ready, 1 = ready about one cycle in three.
   // abortAt >= 0 returns while byte abortAt is being offered.
   task automatic applyStimulus(input int readyMode, input int abortAt);
      bit         held;
      logic [7:0] heldByte;
      int         lastXfer;
      held = 0; lastXfer = -1; nGot = 0; gotDone = 0; doneCycle = -1;
      doneGap = -1; firstValid = -1;
      for (int i = 0; i < 256; i++) got[i] = 8'hxx;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc < 6000; cyc++) begin
         if (cyc == 1) begin
            checkOutput("busy_after_start", busy, 1);
            checkOutput("addr_coef0", mem_address_o, 0);
            checkOutput("coef_err_cleared", coef_err, 0);
         end
         start = (readyMode == 1) && (cyc == 20);
         out_ready = (readyMode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         if (held) begin
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_stable", out_byte, heldByte);
            held = 0;
         end
         if (out_valid && firstValid < 0) firstValid = cyc;
         if (abortAt >= 0 && out_valid && nGot == abortAt) return;
         if (out_valid && out_ready) begin
            got[nGot] = out_byte;
            gotLast[nGot] = out_last;
            errAt[nGot] = coef_err;
            nGot++;
            lastXfer = cyc;
         end else if (out_valid) begin
            held = 1;
            heldByte = out_byte;
         end
         if (done) begin
            gotDone = 1;
            doneCycle = cyc;
            doneGap = cyc - lastXfer;
            doneErr = coef_err;
            doneWok = weight_ok;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("done_seen", gotDone, 1);
      if (gotDone) begin
         @(negedge clk);
         checkOutput("done_one_pulse", done, 0);
         checkOutput("busy_dropped", busy, 0);
      end
   endtask

   task automatic checkStream(input logic [7:0] firstExp, input logic [7:0] lastExp, input bit timed);
      checkOutput("byte_count", nGot, NB);
      checkOutput("byte0_const", got[0], firstExp);
      checkOutput("byte189_const", got[NB-1], lastExp);
      checkOutput("done_gap", doneGap, 1);
      if (timed) begin
         checkOutput("first_valid_lat", firstValid, 6);
         checkOutput("done_latency", doneCycle, 189 * 6 + 3 + 1);
      end
      for (int i = 0; i < NB; i++) begin
         checkOutput($sformatf("byte%0d", i), got[i], modelByte(i));
         checkOutput($sformatf("last%0d", i), gotLast[i], (i == NB - 1));
      end
   endtask

   initial begin
      logic [12:0] pat [0:3];
      bit expW285;
      pat[0] = 13'h0001; pat[1] = 13'h1FFF; pat[2] = 13'h0000; pat[3] = 13'h0001;
`ifdef SMALL_ENCODE_WEIGHT_CHECK_EN
      expW285 = 1'b0;
`else
      expW285 = 1'b1;
`endif
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 13'h0000;
      repeat (3) @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_byte", out_byte, 0);
      checkOutput("rst_out_last", out_last, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_coef_err", coef_err, 0);
      checkOutput("rst_weight_ok", weight_ok, 1);
      checkOutput("rst_addr", mem_address_o, 0);
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] all-zero memory, ready high");
      applyStimulus(0, -1);
      checkStream(8'h55, 8'h01, 1);
      checkOutput("zero_coef_err", doneErr, 0);

      $display("[TB] +1,-1,0,+1 pattern, ready high");
      for (int i = 0; i < NCOF; i++) mem[i] = pat[i % 4];
      applyStimulus(0, -1);
      checkStream(8'h92, 8'h02, 1);

      $display("[TB] same pattern with random stalls and a stray start");
      applyStimulus(1, -1);
      checkStream(8'h92, 8'h02, 0);

      $display("[TB] out-of-range coefficient at address 10");
      for (int i = 0; i < NCOF; i++) mem[i] = 13'h0000;
      mem[10] = 13'h0005;
      applyStimulus(0, -1);
      checkStream(8'h55, 8'h01, 1);
      checkOutput("err_before_addr10", errAt[1], 0);
      checkOutput("err_at_byte2", errAt[2], 1);
      checkOutput("err_at_done", doneErr, 1);

      $display("[TB] weight 286");
      mem[10] = 13'h0000;
      for (int i = 0; i < 286; i++) mem[i] = (i % 2 == 0) ? 13'h0001 : 13'h1FFF;
      applyStimulus(0, -1);
      checkStream(8'h22, 8'h01, 1);
      checkOutput("weight286_ok", doneWok, 1);
      checkOutput("weight286_err", doneErr, 0);

      $display("[TB] weight 285");
      mem[285] = 13'h0000;
      applyStimulus(0, -1);
      checkStream(8'h22, 8'h01, 1);
      checkOutput("weight285_ok", doneWok, expW285);

      $display("[TB] reset during byte 50");
      applyStimulus(0, 50);
      checkOutput("abort_point", nGot, 50);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", out_valid, 0);
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_byte", out_byte, 0);
      checkOutput("mid_rst_addr", mem_address_o, 0);
      checkOutput("mid_rst_wok", weight_ok, 1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("mid_rst_no_done", done, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("idle_no_done", done, 0);
         checkOutput("idle_no_valid", out_valid, 0);
      end
      applyStimulus(0, -1);
      checkStream(8'h22, 8'h01, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/small_encode.md
Name: small_encode

Overview:
- Downstream consumer of the small-polynomial generator. After generation completes, this block reads the P ternary coefficients back from the shared coefficient memory.
- Each coefficient c in {-1,0,1} maps to c+1 in {0,1,2}. Four coefficients pack into one byte (Small_encode): b = x0 + 4*x1 + 16*x2 + 64*x3.
- Bytes are emitted on a valid/ready stream toward the key/ciphertext serializer.

Parameters:
- P, 757, number of coefficients (polynomial degree bound).
- W, 286, required Hamming weight of a valid small polynomial.
- AW, 11, memory address width.
- DW, 13, memory data width; coefficients are stored as DW-bit two's complement.
- BASE_ADDR, 0, memory address of coefficient 0.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, begin encoding; sampled only in IDLE.
- mem_address_o, out, AW, read address to coefficient memory.
- mem_output, in, DW, read data; valid exactly 1 cycle after the address is driven.
- out_byte, out, 8, encoded byte.
- out_valid, out, 1, out_byte valid.
- out_ready, in, 1, downstream accepts when out_valid && out_ready.
- out_last, out, 1, marks the final byte (index (P+3)/4-1).
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse after the last byte is accepted.
- coef_err, out, 1, sticky: some coefficient was outside {-1,0,1}.
- weight_ok, out, 1, weight check result; valid while done=1 and held until the next start.

Behaviour:
- Reset values: every output 0 except weight_ok=1. State=IDLE, byte counter=0, coefficient index=0.
- States: IDLE, FETCH, EMIT, FIN.
- IDLE:
  - On start: clear coef_err and the weight counter, set index k=0, assert busy, go to FETCH.
  - start while busy is ignored.
- FETCH, per group:
  - The group has N = min(4, P-k) coefficients.
  - Drive mem_address_o = BASE_ADDR+k+j for j=0..N-1 on consecutive cycles.
  - Capture mem_output one cycle later into slot j; the state lasts N+1 cycles.
  - Slots j>=N are padded with 0, not code 1. For P=757 the last byte therefore carries only x0.
- Coefficient mapping (combinational):
  - 13'h0001 -> 2; 13'h0000 -> 1; 13'h1FFF -> 0.
  - Any other value sets coef_err and maps to 1.
- EMIT:
  - out_valid=1; out_byte and out_last stay stable until the transfer.
  - Back-pressure may last indefinitely.
  - On transfer: k += N. If k==P, go to FIN, else go to FETCH.
  - out_valid drops the cycle after the transfer.
- FIN: pulse done for 1 cycle, drop busy, return to IDLE.
  - mem_address_o holds its last value while not in FETCH.
- Latency:
  - start sampled at edge t: the address for coefficient 0 is driven in cycle t+1.
  - The first out_valid is in cycle t+6.
  - With out_ready tied high, each full byte takes 6 cycles. Total for P=757: 189*6 + 3 + 1 (FIN) cycles after acceptance.
- Byte count: NBYTES = (P+3)/4 = 190 for the defaults.
- Reset mid-operation: immediately return to IDLE with reset output values. The partial stream is abandoned and no done is emitted.
- Arithmetic: out_byte = {x3,x2,x1,x0}, each 2 bits. No carries.

Optional Feature:
- SMALL_ENCODE_WEIGHT_CHECK_EN defined:
  - A 10-bit counter increments for each fetched coefficient equal to +1 or -1.
  - At FIN, weight_ok = (count == W), registered and held until the next start.
  - Out-of-range coefficients do not count.
- Not defined: no counter; weight_ok is tied to 1.

Decomposition:
- Shared package sntrup_pkg holds:
  - P, W, NBYTES.
  - The ternary codes TERN_NEG=2'd0, TERN_ZERO=2'd1, TERN_POS=2'd2.
  - The state enum type.
- One sub-module, small_tern_map: combinational DW-bit coefficient -> 2-bit code plus err flag.
- The FSM, slot registers and counters live in small_encode.

Test Plan:
- Memory all 0, out_ready=1, start pulse -> 190 bytes; bytes 0..188 = 8'h55, byte 189 = 8'h01 with out_last=1; done one cycle after; coef_err=0.
- Memory pattern +1,-1,0,+1 repeating (last coeff +1) -> every full byte = 2+0*4+1*16+2*64 = 8'h92; last byte 8'h02.
- out_ready toggled 1-of-3 cycles with random stalls -> byte sequence identical to the stall-free run; out_byte stable while out_valid && !out_ready.
- Coefficient 5 written to address 10 -> coef_err=1 from the fetch of address 10 through done; byte 2 has slot 2 = code 1; coef_err is cleared on the next start.
- With SMALL_ENCODE_WEIGHT_CHECK_EN: exactly 286 nonzeros -> weight_ok=1 at done; 285 nonzeros -> weight_ok=0. Without the macro -> weight_ok=1 in both cases.
- Assert rst during byte 50 -> outputs return to reset values asynchronously, no done; a fresh start then produces the full 190-byte stream.
